// File: rtl/fetch_stage.sv
// Instruction fetch stage: one outstanding imem request at a time, next PC chosen from the branch predictor.
// Fetched words and their prediction metadata are buffered in a small FIFO for decode; ROB redirects flush it.
module fetch_stage #(
    parameter int          GH       = 8,
    parameter int          FQ_DEPTH = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          clock,
    input  logic          reset,

    output logic          predict_req_valid_o,
    output logic [31:0]   predict_req_pc_o,
    output logic          predict_req_used_o,
    input  logic          predict_taken_i,
    input  logic [31:0]   predict_target_i,
    input  logic [GH-1:0] predict_ghr_snapshot_i,

    output logic          imem_req_valid_o,
    output logic [31:0]   imem_req_addr_o,
    input  logic          imem_req_ready_i,
    input  logic          imem_resp_valid_i,
    input  logic [31:0]   imem_resp_data_i,

    input  logic          redirect_valid_i,
    input  logic [31:0]   redirect_pc_i,

    output logic          fq_out_valid_o,
    input  logic          fq_out_ready_i,
    output logic [31:0]   fq_out_inst_o,
    output logic [31:0]   fq_out_pc_o,
    output logic          fq_out_pred_taken_o,
    output logic [31:0]   fq_out_pred_target_o,
    output logic [GH-1:0] fq_out_ghr_o
);

    localparam int AW = $clog2(FQ_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   pc_q, pc_d;

    logic [31:0]   pend_pc_q, pend_pc_d;
    logic          pend_taken_q, pend_taken_d;
    logic [31:0]   pend_target_q, pend_target_d;
    logic [GH-1:0] pend_ghr_q, pend_ghr_d;

    logic [AW:0]   wptr_q, wptr_d;
    logic [AW:0]   rptr_q, rptr_d;

    logic [31:0]   fq_inst_q   [FQ_DEPTH];
    logic [31:0]   fq_inst_d   [FQ_DEPTH];
    logic [31:0]   fq_pc_q     [FQ_DEPTH];
    logic [31:0]   fq_pc_d     [FQ_DEPTH];
    logic          fq_taken_q  [FQ_DEPTH];
    logic          fq_taken_d  [FQ_DEPTH];
    logic [31:0]   fq_target_q [FQ_DEPTH];
    logic [31:0]   fq_target_d [FQ_DEPTH];
    logic [GH-1:0] fq_ghr_q    [FQ_DEPTH];
    logic [GH-1:0] fq_ghr_d    [FQ_DEPTH];

    logic          fq_full;
    logic          fq_empty;
    logic          fire;
    logic          eff_taken;
    logic [31:0]   next_pc;
    logic          push;
    logic          pop;

    // Pointers carry a wrap bit so full and empty are distinguishable without a separate count.
    always_comb begin
        fq_empty = (wptr_q == rptr_q);
        fq_full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    end

    always_comb begin
        imem_req_valid_o    = (state_q == IDLE) && !redirect_valid_i && !fq_full;
        imem_req_addr_o     = pc_q;
        predict_req_valid_o = imem_req_valid_o;
        predict_req_pc_o    = pc_q;
        fire                = imem_req_valid_o && imem_req_ready_i;
        predict_req_used_o  = fire;
        eff_taken           = predict_taken_i && (predict_target_i != 32'd0);
        next_pc             = eff_taken ? predict_target_i : pc_q + 32'd4;
        push                = (state_q == WAIT) && imem_resp_valid_i && !redirect_valid_i;
        pop                 = !fq_empty && fq_out_ready_i && !redirect_valid_i;
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        pend_pc_d     = pend_pc_q;
        pend_taken_d  = pend_taken_q;
        pend_target_d = pend_target_q;
        pend_ghr_d    = pend_ghr_q;
        if (redirect_valid_i) begin
            pc_d = redirect_pc_i;
            // An outstanding request must still be drained before a new one can go out.
            case (state_q)
                WAIT:    state_d = imem_resp_valid_i ? IDLE : DRAIN;
                DRAIN:   state_d = imem_resp_valid_i ? IDLE : DRAIN;
                default: state_d = IDLE;
            endcase
        end else begin
            case (state_q)
                IDLE: begin
                    if (fire) begin
                        pend_pc_d     = pc_q;
                        pend_taken_d  = eff_taken;
                        pend_target_d = next_pc;
                        pend_ghr_d    = predict_ghr_snapshot_i;
                        pc_d          = next_pc;
                        state_d       = WAIT;
                    end
                end
                WAIT: begin
                    if (imem_resp_valid_i) state_d = IDLE;
                end
                DRAIN: begin
                    if (imem_resp_valid_i) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        fq_inst_d   = fq_inst_q;
        fq_pc_d     = fq_pc_q;
        fq_taken_d  = fq_taken_q;
        fq_target_d = fq_target_q;
        fq_ghr_d    = fq_ghr_q;
        if (redirect_valid_i) begin
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            if (push) begin
                fq_inst_d[wptr_q[AW-1:0]]   = imem_resp_data_i;
                fq_pc_d[wptr_q[AW-1:0]]     = pend_pc_q;
                fq_taken_d[wptr_q[AW-1:0]]  = pend_taken_q;
                fq_target_d[wptr_q[AW-1:0]] = pend_target_q;
                fq_ghr_d[wptr_q[AW-1:0]]    = pend_ghr_q;
                wptr_d = wptr_q + {{AW{1'b0}}, 1'b1};
            end
            if (pop) begin
                rptr_d = rptr_q + {{AW{1'b0}}, 1'b1};
            end
        end
    end

    always_comb begin
        fq_out_valid_o       = !fq_empty;
        fq_out_inst_o        = fq_inst_q[rptr_q[AW-1:0]];
        fq_out_pc_o          = fq_pc_q[rptr_q[AW-1:0]];
        fq_out_pred_taken_o  = fq_taken_q[rptr_q[AW-1:0]];
        fq_out_pred_target_o = fq_target_q[rptr_q[AW-1:0]];
        fq_out_ghr_o         = fq_ghr_q[rptr_q[AW-1:0]];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            pend_pc_q     <= '0;
            pend_taken_q  <= 1'b0;
            pend_target_q <= '0;
            pend_ghr_q    <= '0;
            wptr_q        <= '0;
            rptr_q        <= '0;
            for (int i = 0; i < FQ_DEPTH; i++) begin
                fq_inst_q[i]   <= '0;
                fq_pc_q[i]     <= '0;
                fq_taken_q[i]  <= 1'b0;
                fq_target_q[i] <= '0;
                fq_ghr_q[i]    <= '0;
            end
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            pend_pc_q     <= pend_pc_d;
            pend_taken_q  <= pend_taken_d;
            pend_target_q <= pend_target_d;
            pend_ghr_q    <= pend_ghr_d;
            wptr_q        <= wptr_d;
            rptr_q        <= rptr_d;
            fq_inst_q     <= fq_inst_d;
            fq_pc_q       <= fq_pc_d;
            fq_taken_q    <= fq_taken_d;
            fq_target_q   <= fq_target_d;
            fq_ghr_q      <= fq_ghr_d;
        end
    end

endmodule
